wb_scratch_responder: RTL and testbench

//  Pipelined Wishbone B4 slave holding a 2**ADDR_WIDTH x 32-bit scratch RAM.

---
 rtl/wb_scratch_responder.sv | 170 +++++++++++++++++
 tb/tb_wb_scratch_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scratch_responder.sv
// wb_scratch_responder
//   Pipelined Wishbone B4 slave backed by a 2**ADDR_WIDTH x 32-bit scratch RAM.
//   Accepted requests are queued and answered strictly in order, each one
//   LATENCY+2 cycles after reaching the queue head. This lets the host-side
//   accessor be exercised against real stall, latency and byte-select behaviour.
//
//   Optional feature macro: WB_SCRATCH_ERR_EN
//     defined   : out-of-range (adr[31:ADDR_WIDTH+2]!=0) or misaligned
//                 (adr[1:0]!=0) requests complete with wb_err_o and leave
//                 the RAM untouched.
//     undefined : those address bits are ignored (aliasing), wb_err_o is 0.
//
// Ports
//   clk_sys_i   system clock
//   rst_i       synchronous reset, active high
//   wb_cyc_i    bus cycle; dropping it flushes all queued requests
//   wb_stb_i    request strobe
//   wb_we_i     1 = write, 0 = read
//   wb_adr_i    byte address, word index = adr[ADDR_WIDTH+1:2]
//   wb_sel_i    byte enables for writes
//   wb_dat_i    write data
//   wb_dat_o    read data while wb_ack_o is high, else 0
//   wb_ack_o    one-cycle completion pulse
//   wb_err_o    one-cycle error pulse
//   wb_stall_o  queue full, request not accepted this cycle
module wb_scratch_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int LATENCY     = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk_sys_i,
   input  logic        rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_stall_o
);

   localparam int PW    = $clog2(QUEUE_DEPTH);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [3:0] LAT = 4'(LATENCY);

   // Only what the response stage needs is stored: the error decision is
   // made at accept time so the head entry carries a single flag.
   typedef struct packed {
      logic                  we;
      logic                  bad;
      logic [ADDR_WIDTH-1:0] idx;
      logic [3:0]            sel;
      logic [31:0]           dat;
   } req_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   req_t          queue [QUEUE_DEPTH];
   logic [31:0]   mem   [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   req_t          push_req, head;
   logic          abort, push, resp;

   // Reset and a dropped cycle share one path: flush queue, FSM to IDLE.
   assign abort      = rst_i | ~wb_cyc_i;
   // Registered count only, so a pop does not unstall in the same cycle.
   assign wb_stall_o = (count == (PW+1)'(QUEUE_DEPTH));
   assign push       = wb_cyc_i & wb_stb_i & ~wb_stall_o;
   assign head       = queue[rd_ptr];
   // Gate with abort so a cycle being dropped never sees a response.
   assign resp       = (state == RESP) & ~abort;

   always_comb begin
      push_req.we  = wb_we_i;
      push_req.bad = 1'b0;
      push_req.idx = wb_adr_i[ADDR_WIDTH+1:2];
      push_req.sel = wb_sel_i;
      push_req.dat = wb_dat_i;
`ifdef WB_SCRATCH_ERR_EN
      push_req.bad = (|wb_adr_i[31:ADDR_WIDTH+2]) | (|wb_adr_i[1:0]);
`endif
   end

`ifndef WB_SCRATCH_ERR_EN
   // Upper and byte-offset address bits intentionally alias.
   logic unused;
   assign unused = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif

   // Request queue storage (not reset; validity is tracked by count).
   always_ff @(posedge clk_sys_i) begin
      if (push && !abort)
         queue[wr_ptr] <= push_req;
   end

   // Queue pointers and occupancy; pointers wrap naturally (power-of-2 depth).
   always_ff @(posedge clk_sys_i) begin
      if (abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (resp) rd_ptr <= rd_ptr + 1'b1;
         case ({push, resp})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Head FSM state register.
   always_ff @(posedge clk_sys_i) begin
      if (abort) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_nxt = WAIT;
               cnt_nxt   = LAT;
            end
         end
         WAIT: begin
            if (cnt == '0) state_nxt = RESP;
            else           cnt_nxt   = cnt - 1'b1;
         end
         RESP: begin
            // Head pops this cycle; continue if anything is left or arriving.
            if ((count > (PW+1)'(1)) || push) begin
               state_nxt = WAIT;
               cnt_nxt   = LAT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Byte-masked write at response time; RAM is never cleared.
   always_ff @(posedge clk_sys_i) begin
      if (resp && head.we && !head.bad) begin
         for (int b = 0; b < 4; b++)
            if (head.sel[b])
               mem[head.idx][8*b +: 8] <= head.dat[8*b +: 8];
      end
   end

   assign wb_ack_o = resp & ~head.bad;
   assign wb_err_o = resp &  head.bad;
   assign wb_dat_o = (wb_ack_o && !head.we) ? mem[head.idx] : 32'h0;

endmodule

// File: tb/tb_wb_scratch_responder.sv
module tb_wb_scratch_responder;

   logic        clk = 1'b0;
   logic        rst, cyc, stb, we;
   logic [31:0] adr, dat_i, dat_o;
   logic [3:0]  sel;
   logic        ack, err, stall;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] rdq [8];
   int          nack;
   int          first_stall_at;

   wb_scratch_responder #(.ADDR_WIDTH(8), .LATENCY(2), .QUEUE_DEPTH(4)) dut (
      .clk_sys_i (clk),
      .rst_i     (rst),
      .wb_cyc_i  (cyc),
      .wb_stb_i  (stb),
      .wb_we_i   (we),
      .wb_adr_i  (adr),
      .wb_sel_i  (sel),
      .wb_dat_i  (dat_i),
      .wb_dat_o  (dat_o),
      .wb_ack_o  (ack),
      .wb_err_o  (err),
      .wb_stall_o(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   // Single request on an empty queue; lat counts cycles from accept to ack/err.
   task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic e);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
      lat = 0;
      while (!(ack || err) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = dat_o;
      e  = err;
   endtask

   // Back-to-back burst of n requests honouring stall, with a parallel ack monitor.
   task automatic burst(input logic w, input logic [31:0] base, input int n);
      nack = 0;
      first_stall_at = -1;
      fork
         begin
            int acc = 0;
            int g   = 0;
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF;
            while (acc < n && g < 200) begin
               adr   = base + 32'(4 * acc);
               dat_i = 32'h1000_0000 + 32'(acc);
               if (stall) begin
                  if (first_stall_at < 0) first_stall_at = acc;
               end else begin
                  acc++;
               end
               @(negedge clk);
               g++;
            end
            stb = 1'b0; we = 1'b0;
         end
         begin
            for (int c = 0; c < 80; c++) begin
               @(negedge clk);
               if (ack) begin
                  if (nack < 8) rdq[nack] = dat_o;
                  nack++;
               end
            end
         end
      join
   endtask

   // Counts ack/err pulses over a fixed window.
   task automatic count_resp(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (ack || err) n++;
      end
   endtask

   // Present four reads back to back starting at base (queue assumed empty).
   task automatic queue4(input logic [31:0] base);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
      for (int i = 0; i < 4; i++) begin
         adr = base + 32'(4 * i);
         @(negedge clk);
      end
      stb = 1'b0;
   endtask

   initial begin
      int          lat, n, g;
      logic [31:0] rd;
      logic        e;

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = '0; sel = '0; dat_i = '0;

      // Reset
      repeat (3) @(negedge clk);
      chk("rst ack",   32'(ack),   32'h0);
      chk("rst err",   32'(err),   32'h0);
      chk("rst stall", 32'(stall), 32'h0);
      chk("rst dat",   dat_o,      32'h0);
      rst = 1'b0;

      // Basic write/read, latency LATENCY+2
      xact(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, lat, rd, e);
      chk("wr lat", 32'(lat), 32'd4);
      chk("wr err", 32'(e),   32'h0);
      xact(1'b0, 32'h100, 4'hF, 32'h0, lat, rd, e);
      chk("rd lat",  32'(lat), 32'd4);
      chk("rd data", rd,       32'hDEADBEEF);

      // Byte selects
      xact(1'b1, 32'h104, 4'hF, 32'hCAFEBABE, lat, rd, e);
      xact(1'b1, 32'h104, 4'h3, 32'h00001122, lat, rd, e);
      xact(1'b0, 32'h104, 4'h0, 32'h0, lat, rd, e);
      chk("sel 0011", rd, 32'hCAFE1122);
      xact(1'b1, 32'h104, 4'h0, 32'hFFFFFFFF, lat, rd, e);
      chk("sel 0000 lat", 32'(lat), 32'd4);
      xact(1'b0, 32'h104, 4'hF, 32'h0, lat, rd, e);
      chk("sel 0000 keep", rd, 32'hCAFE1122);
      xact(1'b1, 32'h104, 4'h4, 32'h00AB0000, lat, rd, e);
      xact(1'b0, 32'h104, 4'hF, 32'h0, lat, rd, e);
      chk("sel 0100", rd, 32'hCAAB1122);

      // Burst of 6 writes then 6 reads, queue depth 4
      burst(1'b1, 32'h200, 6);
      chk("bw stall at", 32'(first_stall_at), 32'd4);
      chk("bw acks",     32'(nack),           32'd6);
      burst(1'b0, 32'h200, 6);
      chk("br stall at", 32'(first_stall_at), 32'd4);
      chk("br acks",     32'(nack),           32'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("br data%0d", i), rdq[i], 32'h1000_0000 + 32'(i));

      // Drop cyc after two of four queued reads
      queue4(32'h200);
      n = 0; g = 0;
      while (n < 2 && g < 40) begin
         if (ack) begin
            rdq[n] = dat_o;
            n++;
         end
         @(negedge clk);
         g++;
      end
      chk("abort pre acks", 32'(n), 32'd2);
      chk("abort d0", rdq[0], 32'h1000_0000);
      chk("abort d1", rdq[1], 32'h1000_0001);
      cyc = 1'b0;
      count_resp(20, n);
      chk("abort no acks", 32'(n),     32'd0);
      chk("abort stall",   32'(stall), 32'h0);
      xact(1'b0, 32'h208, 4'hF, 32'h0, lat, rd, e);
      chk("abort new lat",  32'(lat), 32'd4);
      chk("abort new data", rd,       32'h1000_0002);

      // Reset mid-burst
      queue4(32'h200);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid stall", 32'(stall), 32'h0);
      chk("rst mid dat",   dat_o,      32'h0);
      count_resp(20, n);
      chk("rst mid acks", 32'(n), 32'd0);
      xact(1'b0, 32'h20C, 4'hF, 32'h0, lat, rd, e);
      chk("rst mid new", rd, 32'h1000_0003);

      // Address aliasing / error responses
      xact(1'b1, 32'h000, 4'hF, 32'h0BADF00D, lat, rd, e);
`ifdef WB_SCRATCH_ERR_EN
      xact(1'b0, 32'h400, 4'hF, 32'h0, lat, rd, e);
      chk("oor err",  32'(e),   32'h1);
      chk("oor lat",  32'(lat), 32'd4);
      chk("oor dat",  rd,       32'h0);
      xact(1'b1, 32'h400, 4'hF, 32'h12345678, lat, rd, e);
      xact(1'b0, 32'h000, 4'hF, 32'h0, lat, rd, e);
      chk("oor no wr", rd, 32'h0BADF00D);
      xact(1'b0, 32'h102, 4'hF, 32'h0, lat, rd, e);
      chk("misalign err", 32'(e), 32'h1);
`else
      xact(1'b0, 32'h400, 4'hF, 32'h0, lat, rd, e);
      chk("alias err",  32'(e), 32'h0);
      chk("alias data", rd,     32'h0BADF00D);
      xact(1'b0, 32'h102, 4'hF, 32'h0, lat, rd, e);
      chk("offset data", rd, 32'hDEADBEEF);
      chk("offset lat",  32'(lat), 32'd4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
